// File: rtl/uart_tx_bridge.sv
// Byte-stream sink: FIFO-buffered 8N1 UART transmitter, LSB first, fixed clocks per bit.
// Optional even parity bit between data and stop when UART_TX_PARITY_EN is defined.
module uart_tx_bridge #(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 16,
    parameter int STOP_BITS    = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [7:0]                  rxd,
    input  logic                        rx_dv,
    output logic                        uart_txd,
    output logic                        busy,
    output logic                        fifo_full,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level,
    output logic                        overflow
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int BW = $clog2(CLKS_PER_BIT);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
        ST_PARITY = 3'd3,
`endif
        ST_STOP   = 3'd4
    } state_t;

`ifdef UART_TX_PARITY_EN
    function automatic logic even_parity(input logic [7:0] data);
        even_parity = ^data;
    endfunction
`endif

    logic [7:0]    mem_r [FIFO_DEPTH];
    logic [AW:0]   wr_ptr_r;
    logic [AW:0]   rd_ptr_r;
    logic [LW-1:0] level_r;
    logic [LW-1:0] level_nxt_s;
    logic          fifo_full_r;
    logic          overflow_r;
    state_t        state_r;
    logic [BW-1:0] baud_r;
    logic [2:0]    bit_cnt_r;
    logic [7:0]    shift_r;
    logic          txd_r;
    logic          busy_r;
    logic          wr_en_s;
    logic          pop_s;
    logic          bit_end_s;
    logic          line_s;
    logic [7:0]    head_s;
`ifdef UART_TX_PARITY_EN
    logic          parity_r;
`endif

    assign head_s = mem_r[rd_ptr_r[AW-1:0]];

    // Write/pop decisions and next FIFO occupancy; a write while full is dropped even if a pop coincides.
    always_comb begin
        wr_en_s   = rx_dv & ~fifo_full_r;
        bit_end_s = (baud_r == BW'(CLKS_PER_BIT - 1));
        pop_s     = 1'b0;
        if (state_r == ST_IDLE) begin
            pop_s = (level_r != {LW{1'b0}});
        end else if ((state_r == ST_STOP) && bit_end_s && (bit_cnt_r == 3'(STOP_BITS - 1))) begin
            pop_s = (level_r != {LW{1'b0}});
        end else begin
            pop_s = 1'b0;
        end
        case ({wr_en_s, pop_s})
            2'b10:   level_nxt_s = level_r + LW'(1);
            2'b01:   level_nxt_s = level_r - LW'(1);
            default: level_nxt_s = level_r;
        endcase
    end

    // Serial line value for the current state; registered one cycle later into txd_r.
    always_comb begin
        case (state_r)
            ST_IDLE:   line_s = 1'b1;
            ST_START:  line_s = 1'b0;
            ST_DATA:   line_s = shift_r[0];
`ifdef UART_TX_PARITY_EN
            ST_PARITY: line_s = parity_r;
`endif
            ST_STOP:   line_s = 1'b1;
            default:   line_s = 1'b1;
        endcase
    end

    // FIFO storage array.
    always_ff @(posedge clk) begin
        if (wr_en_s && !rst) begin
            mem_r[wr_ptr_r[AW-1:0]] <= rxd;
        end
    end

    // FIFO pointers, occupancy, full and sticky overflow flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r    <= {LW{1'b0}};
            rd_ptr_r    <= {LW{1'b0}};
            level_r     <= {LW{1'b0}};
            fifo_full_r <= 1'b0;
            overflow_r  <= 1'b0;
        end else begin
            if (wr_en_s) begin
                wr_ptr_r <= wr_ptr_r + LW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + LW'(1);
            end
            if (rx_dv && fifo_full_r) begin
                overflow_r <= 1'b1;
            end
            level_r     <= level_nxt_s;
            fifo_full_r <= (level_nxt_s == LW'(FIFO_DEPTH));
        end
    end

    // Frame sequencer with baud and bit counters; line and busy are registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            baud_r    <= {BW{1'b0}};
            bit_cnt_r <= 3'd0;
            shift_r   <= 8'd0;
            txd_r     <= 1'b1;
            busy_r    <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_r  <= 1'b0;
`endif
        end else begin
            txd_r  <= line_s;
            busy_r <= (state_r != ST_IDLE) || (level_r != {LW{1'b0}});
            case (state_r)
                ST_IDLE: begin
                    baud_r    <= {BW{1'b0}};
                    bit_cnt_r <= 3'd0;
                    if (pop_s) begin
                        shift_r <= head_s;
`ifdef UART_TX_PARITY_EN
                        parity_r <= even_parity(head_s);
`endif
                        state_r <= ST_START;
                    end
                end
                ST_START: begin
                    if (bit_end_s) begin
                        baud_r    <= {BW{1'b0}};
                        bit_cnt_r <= 3'd0;
                        state_r   <= ST_DATA;
                    end else begin
                        baud_r <= baud_r + BW'(1);
                    end
                end
                ST_DATA: begin
                    if (bit_end_s) begin
                        baud_r  <= {BW{1'b0}};
                        shift_r <= {1'b0, shift_r[7:1]};
                        if (bit_cnt_r == 3'd7) begin
                            bit_cnt_r <= 3'd0;
`ifdef UART_TX_PARITY_EN
                            state_r   <= ST_PARITY;
`else
                            state_r   <= ST_STOP;
`endif
                        end else begin
                            bit_cnt_r <= bit_cnt_r + 3'd1;
                        end
                    end else begin
                        baud_r <= baud_r + BW'(1);
                    end
                end
`ifdef UART_TX_PARITY_EN
                ST_PARITY: begin
                    if (bit_end_s) begin
                        baud_r    <= {BW{1'b0}};
                        bit_cnt_r <= 3'd0;
                        state_r   <= ST_STOP;
                    end else begin
                        baud_r <= baud_r + BW'(1);
                    end
                end
`endif
                ST_STOP: begin
                    if (bit_end_s) begin
                        baud_r <= {BW{1'b0}};
                        if (bit_cnt_r == 3'(STOP_BITS - 1)) begin
                            bit_cnt_r <= 3'd0;
                            // Pending byte chains straight into the next start bit.
                            if (pop_s) begin
                                shift_r <= head_s;
`ifdef UART_TX_PARITY_EN
                                parity_r <= even_parity(head_s);
`endif
                                state_r <= ST_START;
                            end else begin
                                state_r <= ST_IDLE;
                            end
                        end else begin
                            bit_cnt_r <= bit_cnt_r + 3'd1;
                        end
                    end else begin
                        baud_r <= baud_r + BW'(1);
                    end
                end
                default: begin
                    state_r   <= ST_IDLE;
                    baud_r    <= {BW{1'b0}};
                    bit_cnt_r <= 3'd0;
                end
            endcase
        end
    end

    assign uart_txd   = txd_r;
    assign busy       = busy_r;
    assign fifo_full  = fifo_full_r;
    assign fifo_level = level_r;
    assign overflow   = overflow_r;

endmodule

// File: tb/tb_uart_tx_bridge.sv
// Self-checking bench for uart_tx_bridge: decodes the serial line cycle by cycle against
// frames built from the byte values, with directed FIFO/overflow/reset scenarios.
module tb_uart_tx_bridge;

    localparam int CPB   = 4;
    localparam int DEPTH = 16;
    localparam int STOPB = 1;
`ifdef UART_TX_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int NBITS = 10 + STOPB - 1 + PAR;
    localparam int FRAME = NBITS * CPB;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] rxd = 8'd0;
    logic       rx_dv = 1'b0;
    logic       uart_txd;
    logic       busy;
    logic       fifo_full;
    logic [4:0] fifo_level;
    logic       overflow;

    int n_vec = 0;
    int n_err = 0;

    uart_tx_bridge #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH), .STOP_BITS(STOPB)) dut (
        .clk(clk), .rst(rst), .rxd(rxd), .rx_dv(rx_dv), .uart_txd(uart_txd),
        .busy(busy), .fifo_full(fifo_full), .fifo_level(fifo_level), .overflow(overflow)
    );

    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Waits up to max_wait cycles for a start bit, then checks every line cycle of the frame.
    task automatic rx_frame(input logic [7:0] exp_byte, input int max_wait, output int waited);
        logic pat [NBITS];
        pat[0] = 1'b0;
        for (int i = 0; i < 8; i++) pat[i + 1] = exp_byte[i];
        for (int i = 9; i < NBITS; i++) pat[i] = (PAR == 1 && i == 9) ? ^exp_byte : 1'b1;
        waited = 0;
        while (uart_txd !== 1'b0 && waited < max_wait) begin
            @(negedge clk);
            waited++;
        end
        n_vec++;
        if (uart_txd !== 1'b0) begin
            n_err++;
            $display("FAIL frame_start byte=%02h: line=%b after %0d cycles, required 0", exp_byte, uart_txd, waited);
        end else begin
            for (int b = 0; b < NBITS; b++) begin
                for (int c = 0; c < CPB; c++) begin
                    n_vec++;
                    if (uart_txd !== pat[b]) begin
                        n_err++;
                        $display("FAIL frame_bit byte=%02h bit=%0d cyc=%0d: line=%b required %b", exp_byte, b, c, uart_txd, pat[b]);
                    end
                    if (c == 0) begin
                        n_vec++;
                        if (busy !== 1'b1) begin
                            n_err++;
                            $display("FAIL busy_in_frame byte=%02h bit=%0d: busy=%b required 1", exp_byte, b, busy);
                        end
                    end
                    @(negedge clk);
                end
            end
        end
    endtask

    task automatic check_idle(input string tag);
        n_vec++;
        if (uart_txd !== 1'b1 || busy !== 1'b0 || fifo_level !== 5'd0) begin
            n_err++;
            $display("FAIL %s: txd=%b busy=%b level=%0d, required 1 0 0", tag, uart_txd, busy, fifo_level);
        end
    endtask

    task automatic check_quiet(input string tag, input int cycles);
        int lows = 0;
        for (int i = 0; i < cycles; i++) begin
            if (uart_txd !== 1'b1) lows++;
            @(negedge clk);
        end
        n_vec++;
        if (lows != 0) begin
            n_err++;
            $display("FAIL %s: line low for %0d cycles, required 0", tag, lows);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        rx_dv = 1'b0;
        repeat (3) @(negedge clk);
        n_vec++;
        if (uart_txd !== 1'b1 || busy !== 1'b0 || fifo_full !== 1'b0 || fifo_level !== 5'd0 || overflow !== 1'b0) begin
            n_err++;
            $display("FAIL reset_state: txd=%b busy=%b full=%b level=%0d ovf=%b, required 1 0 0 0 0",
                     uart_txd, busy, fifo_full, fifo_level, overflow);
        end
        rst = 1'b0;
        check_quiet("idle_after_reset", 8);
    endtask

    task automatic test_single(input logic [7:0] b);
        int w;
        rxd = b;
        rx_dv = 1'b1;
        @(negedge clk);
        rx_dv = 1'b0;
        rx_frame(b, 10, w);
        n_vec++;
        if (w != 2) begin
            n_err++;
            $display("FAIL start_latency byte=%02h: %0d cycles, required 2", b, w);
        end
        check_idle("single_end");
    endtask

    task automatic test_back_to_back(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
        int w;
        logic [7:0] v [3];
        v[0] = b0; v[1] = b1; v[2] = b2;
        for (int i = 0; i < 3; i++) begin
            rxd = v[i];
            rx_dv = 1'b1;
            @(negedge clk);
        end
        rx_dv = 1'b0;
        n_vec++;
        if (fifo_level !== 5'd2) begin
            n_err++;
            $display("FAIL b2b_level: level=%0d required 2", fifo_level);
        end
        for (int i = 0; i < 3; i++) begin
            rx_frame(v[i], (i == 0) ? 4 : 0, w);
            n_vec++;
            if (w != 0) begin
                n_err++;
                $display("FAIL b2b_gap frame=%0d: %0d idle cycles, required 0", i, w);
            end
        end
        check_idle("b2b_end");
    endtask

    task automatic test_overflow();
        int w;
        fork
            begin
                for (int i = 0; i < 18; i++) begin
                    rxd = 8'(i);
                    rx_dv = 1'b1;
                    @(negedge clk);
                end
                rx_dv = 1'b0;
                n_vec++;
                if (fifo_full !== 1'b1 || fifo_level !== 5'd16 || overflow !== 1'b1) begin
                    n_err++;
                    $display("FAIL ovf_fill: full=%b level=%0d ovf=%b, required 1 16 1", fifo_full, fifo_level, overflow);
                end
            end
            begin
                for (int i = 0; i < 17; i++) rx_frame(8'(i), (i == 0) ? 10 : 0, w);
            end
        join
        n_vec++;
        if (overflow !== 1'b1) begin
            n_err++;
            $display("FAIL ovf_sticky: ovf=%b required 1", overflow);
        end
        check_idle("ovf_end");
        check_quiet("ovf_dropped_byte", 2 * FRAME);
    endtask

    task automatic test_reset_mid_frame();
        rxd = 8'hC3;
        rx_dv = 1'b1;
        @(negedge clk);
        rxd = 8'h99;
        @(negedge clk);
        rx_dv = 1'b0;
        repeat (18) @(negedge clk);
        n_vec++;
        if (uart_txd !== 1'b0) begin
            n_err++;
            $display("FAIL mid_frame_bit3: line=%b required 0", uart_txd);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_vec++;
        if (uart_txd !== 1'b1 || busy !== 1'b0 || fifo_level !== 5'd0 || overflow !== 1'b0) begin
            n_err++;
            $display("FAIL reset_mid_frame: txd=%b busy=%b level=%0d ovf=%b, required 1 0 0 0",
                     uart_txd, busy, fifo_level, overflow);
        end
        check_quiet("no_resume", 2 * FRAME);
        test_single(8'h3C);
    endtask

    task automatic test_full_pop();
        int w;
        logic [7:0] v [17];
        for (int i = 0; i < 17; i++) v[i] = 8'($urandom_range(0, 255));
        fork
            begin
                for (int i = 0; i < 17; i++) begin
                    rxd = v[i];
                    rx_dv = 1'b1;
                    @(negedge clk);
                end
                rx_dv = 1'b0;
                repeat (FRAME - 16) @(negedge clk);
                n_vec++;
                if (fifo_level !== 5'd16 || fifo_full !== 1'b1 || overflow !== 1'b0) begin
                    n_err++;
                    $display("FAIL full_before_pop: level=%0d full=%b ovf=%b, required 16 1 0", fifo_level, fifo_full, overflow);
                end
                rxd = 8'hEE;
                rx_dv = 1'b1;
                @(negedge clk);
                rx_dv = 1'b0;
                n_vec++;
                if (fifo_level !== 5'd15 || fifo_full !== 1'b0 || overflow !== 1'b1) begin
                    n_err++;
                    $display("FAIL write_full_with_pop: level=%0d full=%b ovf=%b, required 15 0 1", fifo_level, fifo_full, overflow);
                end
            end
            begin
                for (int i = 0; i < 17; i++) rx_frame(v[i], (i == 0) ? 10 : 0, w);
            end
        join
        check_idle("full_pop_end");
        check_quiet("full_pop_dropped", 2 * FRAME);
    endtask

    task automatic test_random();
        int w;
        logic [7:0] v [15];
        int gap [15];
        for (int i = 0; i < 15; i++) begin
            v[i] = 8'($urandom_range(0, 255));
            gap[i] = $urandom_range(0, 50);
        end
        fork
            begin
                for (int i = 0; i < 15; i++) begin
                    rxd = v[i];
                    rx_dv = 1'b1;
                    @(negedge clk);
                    rx_dv = 1'b0;
                    repeat (gap[i]) @(negedge clk);
                end
            end
            begin
                for (int i = 0; i < 15; i++) rx_frame(v[i], 2000, w);
            end
        join
        repeat (2) @(negedge clk);
        check_idle("random_end");
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_single(8'hA5);
        test_single(8'h07);
        test_single(8'($urandom_range(0, 255)));
        test_back_to_back(8'h00, 8'hFF, 8'h55);
        test_back_to_back(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
        test_overflow();
        test_reset_mid_frame();
        test_full_pop();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
